// File: rtl/bus_io_scratch_responder.sv
// I/O-mapped scratch RAM responder on the internal MSX bus: data, pointer,
// status/ID and control ports behind a programmable read latency.
module bus_io_scratch_responder #(
  parameter logic [7:0] IO_BASE      = 8'h88,
  parameter int         ADDR_BITS    = 8,
  parameter int         READ_LATENCY = 2,
  parameter logic [5:0] DEVICE_ID    = 6'h2A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bus_address,
  input  logic        bus_ioreq,
  input  logic        bus_memreq,
  input  logic        bus_write,
  input  logic        bus_valid,
  output logic        bus_ready,
  input  logic [7:0]  bus_wdata,
  output logic [7:0]  bus_rdata,
  output logic        bus_rdata_en
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [3:0]           r_count;
  logic [ADDR_BITS-1:0] r_pointer;
  logic                 r_wrap;
  logic [7:0]           r_result;
  logic [7:0]           r_mem [2**ADDR_BITS];

  logic                 w_hit;
  logic                 w_accept;
  logic                 w_acceptRead;
  logic [1:0]           w_port;
  logic                 w_ptrAtEnd;
  logic [ADDR_BITS-1:0] w_ptrNext;
  logic [ADDR_BITS-1:0] w_ptrLoad;
  logic [ADDR_BITS+7:0] w_wdataExt;
  logic [ADDR_BITS+7:0] w_ptrExt;
  logic [7:0]           w_ptrByte;
  logic [7:0]           w_readValue;
  logic                 w_unused;

  assign w_hit        = bus_ioreq && (bus_address[7:2] == IO_BASE[7:2]);
  assign w_accept     = bus_valid && bus_ready && w_hit && !reset;
  assign w_acceptRead = w_accept && !bus_write;
  assign w_port       = bus_address[1:0];
  assign w_ptrAtEnd   = &r_pointer;
  assign w_ptrNext    = r_pointer + 1'b1;

  // Zero-extend before slicing so any ADDR_BITS in 4..10 maps cleanly to/from a byte.
  assign w_wdataExt = {{ADDR_BITS{1'b0}}, bus_wdata};
  assign w_ptrLoad  = w_wdataExt[ADDR_BITS-1:0];
  assign w_ptrExt   = {8'h00, r_pointer};
  assign w_ptrByte  = w_ptrExt[7:0];
  assign w_unused   = &{1'b0, bus_memreq, bus_address[15:8], w_wdataExt, w_ptrExt};

  always_comb begin
    w_readValue = 8'h00;
    unique case (w_port)
      2'd0:    w_readValue = r_mem[r_pointer];
      2'd1:    w_readValue = w_ptrByte;
      2'd2:    w_readValue = {1'b0, r_wrap, DEVICE_ID};
      default: w_readValue = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pointer <= '0;
      r_wrap    <= 1'b0;
      r_result  <= 8'h00;
    end else if (w_accept) begin
      if (!bus_write) r_result <= w_readValue;
      unique case (w_port)
        2'd0: begin
          r_pointer <= w_ptrNext;
          if (w_ptrAtEnd) r_wrap <= 1'b1;
        end
        2'd1: if (bus_write) r_pointer <= w_ptrLoad;
        2'd3: if (bus_write) begin
          if (bus_wdata[0]) r_pointer <= '0;
          if (bus_wdata[1]) r_wrap <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && bus_write && (w_port == 2'd0)) r_mem[r_pointer] <= bus_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)                 r_count <= 4'd0;
    else if (w_acceptRead)     r_count <= 4'(READ_LATENCY);
    else if (r_state == ST_WAIT) r_count <= r_count - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      ST_IDLE: if (w_acceptRead) w_nextState = ST_WAIT;
      ST_WAIT: if (r_count == 4'd1) w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // The strobe is masked during reset so an aborted read never surfaces.
  always_comb begin
    bus_ready    = (r_state == ST_IDLE);
    bus_rdata_en = (r_state == ST_WAIT) && (r_count == 4'd1) && !reset;
    bus_rdata    = bus_rdata_en ? r_result : 8'h00;
  end

endmodule
